// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - memory access op codes, response codes, FSM states and lane helpers
// Shared by the controller, its load extender and the bench.
package mem_access_ctrl_pkg;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_LL   = 4'd6,
    MEM_OP_SB   = 4'd8,
    MEM_OP_SH   = 4'd9,
    MEM_OP_SW   = 4'd10,
    MEM_OP_SC   = 4'd11
  } mem_op_e;

  typedef enum logic [1:0] {
    RESP_EXCP_OK   = 2'b00,
    RESP_EXCP_ADEL = 2'b01,
    RESP_EXCP_ADES = 2'b10,
    RESP_EXCP_TMO  = 2'b11
  } resp_excp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_known(logic [3:0] op);
    case (mem_op_e'(op))
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW, MEM_OP_LL,
      MEM_OP_SB, MEM_OP_SH, MEM_OP_SW, MEM_OP_SC: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(mem_op_e op);
    case (op)
      MEM_OP_SB, MEM_OP_SH, MEM_OP_SW, MEM_OP_SC: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic op_misaligned(mem_op_e op, logic [1:0] lane);
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH:           return lane[0];
      MEM_OP_LW, MEM_OP_LL, MEM_OP_SW, MEM_OP_SC: return lane != 2'b00;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(mem_op_e op, logic [1:0] lane);
    case (op)
      MEM_OP_SB:            return 4'b0001 << lane;
      MEM_OP_SH:            return 4'b0011 << {lane[1], 1'b0};
      MEM_OP_SW, MEM_OP_SC: return 4'b1111;
      default:              return 4'b0000;
    endcase
  endfunction

  // Replicating across lanes lets the RAM take data from any lane the enables select.
  function automatic logic [31:0] store_lane_data(mem_op_e op, logic [31:0] d);
    case (op)
      MEM_OP_SB:            return {4{d[7:0]}};
      MEM_OP_SH:            return {2{d[15:0]}};
      MEM_OP_SW, MEM_OP_SC: return d;
      default:              return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - MEM-stage request/response interface and data RAM bus interface
// The controller takes the slave side of the request interface and the master side of the RAM bus.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              flush;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic [1:0]        resp_excp;
  logic              resp_sc_ok;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, flush,
    input  req_ready, resp_valid, resp_rdata, resp_excp, resp_sc_ok
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, flush,
    output req_ready, resp_valid, resp_rdata, resp_excp, resp_sc_ok
  );
endinterface

interface dram_bus_if #(
  parameter int ADDR_W = 32
);
  logic              dram_req;
  logic [3:0]        dram_we;
  logic [ADDR_W-1:0] dram_addr;
  logic [31:0]       dram_wdata;
  logic              dram_ack;
  logic [31:0]       dram_rdata;

  modport master (
    output dram_req, dram_we, dram_addr, dram_wdata,
    input  dram_ack, dram_rdata
  );

  modport slave (
    input  dram_req, dram_we, dram_addr, dram_wdata,
    output dram_ack, dram_rdata
  );
endinterface

// File: rtl/mem_access_ctrl_load_ext.sv
// rtl/mem_access_ctrl_load_ext.sv - load lane select and sign/zero extension
// Purely combinational; fed with the registered op and byte lane of the access in flight.
module mem_access_ctrl_load_ext
  import mem_access_ctrl_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    case (op)
      MEM_OP_LB:            data = {{24{shifted[7]}}, shifted[7:0]};
      MEM_OP_LBU:           data = {24'h0, shifted[7:0]};
      MEM_OP_LH:            data = {{16{shifted[15]}}, shifted[15:0]};
      MEM_OP_LHU:           data = {16'h0, shifted[15:0]};
      MEM_OP_LW, MEM_OP_LL: data = shifted;
      default:              data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - sequences one load/store at a time onto the single-ported data RAM bus
// Define MEM_LLSC_EN to build LL/SC link tracking; without it LL acts as LW and SC always stores.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BUS_TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_ctrl_if.slave cpu,
  dram_bus_if.master       dram
);

  localparam int TMO_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

  state_e            state;
  mem_op_e           op_q;
  logic [1:0]        lane_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic [1:0]        resp_excp_q;
  logic              resp_sc_ok_q;
  logic              dram_req_q;
  logic [3:0]        dram_we_q;
  logic [ADDR_W-1:0] dram_addr_q;
  logic [31:0]       dram_wdata_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              drop_resp;

  mem_op_e     req_op;
  logic        accept;
  logic        misaligned;
  logic        sc_reject;
  logic        squash;
  logic        timed_out;
  logic [31:0] ext_rdata;

  assign req_op     = mem_op_e'(cpu.req_op);
  assign accept     = (state == ST_IDLE) && cpu.req_valid && req_ready_q &&
                      !cpu.flush && op_known(cpu.req_op);
  assign misaligned = op_misaligned(req_op, cpu.req_addr[1:0]);
  assign squash     = drop_resp || cpu.flush;
  assign timed_out  = (BUS_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

`ifdef MEM_LLSC_EN
  logic              link;
  logic [ADDR_W-3:0] link_addr;
  logic              link_hit;

  assign link_hit  = link && (link_addr == cpu.req_addr[ADDR_W-1:2]);
  assign sc_reject = (req_op == MEM_OP_SC) && !link_hit;
`else
  assign sc_reject = 1'b0;
`endif

  mem_access_ctrl_load_ext u_load_ext (
    .op    (op_q),
    .lane  (lane_q),
    .rdata (dram.dram_rdata),
    .data  (ext_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      op_q         <= MEM_OP_NONE;
      lane_q       <= 2'b00;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_excp_q  <= RESP_EXCP_OK;
      resp_sc_ok_q <= 1'b0;
      dram_req_q   <= 1'b0;
      dram_we_q    <= 4'b0000;
      dram_addr_q  <= '0;
      dram_wdata_q <= 32'h0;
      tmo_cnt      <= '0;
      drop_resp    <= 1'b0;
`ifdef MEM_LLSC_EN
      link         <= 1'b0;
      link_addr    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q         <= req_op;
            lane_q       <= cpu.req_addr[1:0];
            req_ready_q  <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_sc_ok_q <= 1'b0;
            resp_excp_q  <= RESP_EXCP_OK;
            tmo_cnt      <= '0;
            drop_resp    <= 1'b0;
            if (misaligned) begin
              state        <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_excp_q  <= op_is_store(req_op) ? RESP_EXCP_ADES : RESP_EXCP_ADEL;
            end else if (sc_reject) begin
              state        <= ST_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state        <= ST_BUS;
              dram_req_q   <= 1'b1;
              dram_we_q    <= store_be(req_op, cpu.req_addr[1:0]);
              dram_addr_q  <= {cpu.req_addr[ADDR_W-1:2], 2'b00};
              dram_wdata_q <= store_lane_data(req_op, cpu.req_wdata);
            end
`ifdef MEM_LLSC_EN
            // Any SC consumes the link; a plain store to the linked word breaks it.
            if (!misaligned && (req_op == MEM_OP_SC ||
                                (op_is_store(req_op) && link_hit)))
              link <= 1'b0;
`endif
          end
        end

        ST_BUS: begin
          drop_resp <= squash;
          if (dram.dram_ack) begin
            state        <= ST_RESP;
            dram_req_q   <= 1'b0;
            dram_we_q    <= 4'b0000;
            resp_valid_q <= !squash;
            resp_rdata_q <= op_is_store(op_q) ? 32'h0 : ext_rdata;
            resp_sc_ok_q <= (op_q == MEM_OP_SC);
`ifdef MEM_LLSC_EN
            if (op_q == MEM_OP_LL && !squash) begin
              link      <= 1'b1;
              link_addr <= dram_addr_q[ADDR_W-1:2];
            end
`endif
          end else if (timed_out) begin
            state        <= ST_RESP;
            dram_req_q   <= 1'b0;
            dram_we_q    <= 4'b0000;
            resp_valid_q <= !squash;
            resp_excp_q  <= RESP_EXCP_TMO;
          end else if (BUS_TIMEOUT != 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          state        <= ST_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end

        default: begin
          state       <= ST_IDLE;
          req_ready_q <= 1'b1;
          dram_req_q  <= 1'b0;
        end
      endcase
`ifdef MEM_LLSC_EN
      if (cpu.flush)
        link <= 1'b0;
`endif
    end
  end

  assign cpu.req_ready  = req_ready_q;
  assign cpu.resp_valid = resp_valid_q && !cpu.flush;
  assign cpu.resp_rdata = resp_rdata_q;
  assign cpu.resp_excp  = resp_excp_q;
  assign cpu.resp_sc_ok = resp_sc_ok_q;

  assign dram.dram_req   = dram_req_q;
  assign dram.dram_we    = dram_we_q;
  assign dram.dram_addr  = dram_addr_q;
  assign dram.dram_wdata = dram_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
// Runs with BUS_TIMEOUT=4; LL/SC expectations follow whether MEM_LLSC_EN is defined.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(32)) cpu_if ();
  dram_bus_if        #(.ADDR_W(32)) dram_if ();

  mem_access_ctrl #(.ADDR_W(32), .BUS_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cpu   (cpu_if),
    .dram  (dram_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns one cycle after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    cpu_if.req_valid = 1'b1;
    cpu_if.req_op    = op;
    cpu_if.req_addr  = addr;
    cpu_if.req_wdata = wdata;
    step();
    cpu_if.req_valid = 1'b0;
    cpu_if.req_op    = 4'd0;
  endtask

  task automatic ack_cycle(input logic [31:0] rdata);
    dram_if.dram_ack   = 1'b1;
    dram_if.dram_rdata = rdata;
    step();
    dram_if.dram_ack   = 1'b0;
  endtask

  task automatic test_reset();
    step(); step(); step();
    n_cmp++; if (cpu_if.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", cpu_if.req_ready); end
    n_cmp++; if (cpu_if.resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0", cpu_if.resp_valid); end
    n_cmp++; if (cpu_if.resp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_resp_rdata: got %h want 0", cpu_if.resp_rdata); end
    n_cmp++; if (cpu_if.resp_excp !== 2'b00) begin n_err++; $display("FAIL reset_resp_excp: got %b want 00", cpu_if.resp_excp); end
    n_cmp++; if (cpu_if.resp_sc_ok !== 1'b0) begin n_err++; $display("FAIL reset_sc_ok: got %b want 0", cpu_if.resp_sc_ok); end
    n_cmp++; if (dram_if.dram_req !== 1'b0) begin n_err++; $display("FAIL reset_dram_req: got %b want 0", dram_if.dram_req); end
    n_cmp++; if (dram_if.dram_we !== 4'b0000) begin n_err++; $display("FAIL reset_dram_we: got %b want 0000", dram_if.dram_we); end
    n_cmp++; if (dram_if.dram_addr !== 32'h0) begin n_err++; $display("FAIL reset_dram_addr: got %h want 0", dram_if.dram_addr); end
    n_cmp++; if (dram_if.dram_wdata !== 32'h0) begin n_err++; $display("FAIL reset_dram_wdata: got %h want 0", dram_if.dram_wdata); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lb_latency();
    int lat;
    issue(MEM_OP_LB, 32'h0000_0103, 32'h0);
    n_cmp++; if (dram_if.dram_req !== 1'b1) begin n_err++; $display("FAIL lb_dram_req: got %b want 1", dram_if.dram_req); end
    n_cmp++; if (dram_if.dram_we !== 4'b0000) begin n_err++; $display("FAIL lb_dram_we: got %b want 0000", dram_if.dram_we); end
    n_cmp++; if (dram_if.dram_addr !== 32'h0000_0100) begin n_err++; $display("FAIL lb_dram_addr: got %h want 00000100", dram_if.dram_addr); end
    n_cmp++; if (cpu_if.req_ready !== 1'b0) begin n_err++; $display("FAIL lb_req_ready_busy: got %b want 0", cpu_if.req_ready); end
    lat = 1;
    while (cpu_if.resp_valid !== 1'b1 && lat < 20) begin
      dram_if.dram_ack   = (lat == 4);
      dram_if.dram_rdata = 32'h80FF_1234;
      step();
      lat++;
    end
    dram_if.dram_ack = 1'b0;
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL lb_latency: got %0d want 5", lat); end
    n_cmp++; if (cpu_if.resp_rdata !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_rdata: got %h want ffffff80", cpu_if.resp_rdata); end
    n_cmp++; if (cpu_if.resp_excp !== 2'b00) begin n_err++; $display("FAIL lb_excp: got %b want 00", cpu_if.resp_excp); end
    n_cmp++; if (dram_if.dram_req !== 1'b0) begin n_err++; $display("FAIL lb_dram_req_done: got %b want 0", dram_if.dram_req); end
    step();
    n_cmp++; if (cpu_if.resp_valid !== 1'b0) begin n_err++; $display("FAIL lb_resp_one_cycle: got %b want 0", cpu_if.resp_valid); end
    n_cmp++; if (cpu_if.req_ready !== 1'b1) begin n_err++; $display("FAIL lb_req_ready_idle: got %b want 1", cpu_if.req_ready); end
  endtask

  task automatic test_store_lanes();
    issue(MEM_OP_SH, 32'h0000_0202, 32'h0000_BEEF);
    n_cmp++; if (dram_if.dram_we !== 4'b1100) begin n_err++; $display("FAIL sh_we: got %b want 1100", dram_if.dram_we); end
    n_cmp++; if (dram_if.dram_wdata !== 32'hBEEF_BEEF) begin n_err++; $display("FAIL sh_wdata: got %h want beefbeef", dram_if.dram_wdata); end
    n_cmp++; if (dram_if.dram_addr !== 32'h0000_0200) begin n_err++; $display("FAIL sh_addr: got %h want 00000200", dram_if.dram_addr); end
    step();
    n_cmp++; if (dram_if.dram_req !== 1'b1 || dram_if.dram_we !== 4'b1100) begin n_err++; $display("FAIL sh_hold: got req=%b we=%b want req=1 we=1100", dram_if.dram_req, dram_if.dram_we); end
    ack_cycle(32'hDEAD_0000);
    n_cmp++; if (cpu_if.resp_valid !== 1'b1) begin n_err++; $display("FAIL sh_resp_valid: got %b want 1", cpu_if.resp_valid); end
    n_cmp++; if (cpu_if.resp_rdata !== 32'h0) begin n_err++; $display("FAIL sh_rdata: got %h want 0", cpu_if.resp_rdata); end
    n_cmp++; if (cpu_if.resp_sc_ok !== 1'b0) begin n_err++; $display("FAIL sh_sc_ok: got %b want 0", cpu_if.resp_sc_ok); end
    step();
    issue(MEM_OP_SB, 32'h0000_0301, 32'h1234_56AB);
    n_cmp++; if (dram_if.dram_we !== 4'b0010) begin n_err++; $display("FAIL sb_we: got %b want 0010", dram_if.dram_we); end
    n_cmp++; if (dram_if.dram_wdata !== 32'hABAB_ABAB) begin n_err++; $display("FAIL sb_wdata: got %h want abababab", dram_if.dram_wdata); end
    ack_cycle(32'h0);
    step();
    issue(MEM_OP_SW, 32'h0000_0304, 32'hCAFE_F00D);
    n_cmp++; if (dram_if.dram_we !== 4'b1111 || dram_if.dram_wdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL sw_lanes: got we=%b wdata=%h want 1111 cafef00d", dram_if.dram_we, dram_if.dram_wdata); end
    ack_cycle(32'h0);
    step();
  endtask

  task automatic test_load_ext();
    logic [3:0]  t_op  [6];
    logic [31:0] t_adr [6];
    logic [31:0] t_exp [6];
    t_op  = '{MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW, MEM_OP_LB, MEM_OP_LB};
    t_adr = '{32'h101, 32'h102, 32'h102, 32'h100, 32'h100, 32'h102};
    t_exp = '{32'h0000_0012, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_1234, 32'h0000_0034, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_adr[i], 32'h0);
      ack_cycle(32'h80FF_1234);
      n_cmp++; if (cpu_if.resp_valid !== 1'b1 || cpu_if.resp_rdata !== t_exp[i]) begin n_err++; $display("FAIL load_ext_%0d: got valid=%b rdata=%h want 1 %h", i, cpu_if.resp_valid, cpu_if.resp_rdata, t_exp[i]); end
      step();
    end
  endtask

  task automatic test_misaligned();
    logic [3:0]  t_op  [6];
    logic [31:0] t_adr [6];
    logic [1:0]  t_exc [6];
    t_op  = '{MEM_OP_LW, MEM_OP_SW, MEM_OP_LH, MEM_OP_SH, MEM_OP_SC, MEM_OP_LHU};
    t_adr = '{32'h101, 32'h102, 32'h103, 32'h201, 32'h402, 32'h001};
    t_exc = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_adr[i], 32'h1111_1111);
      n_cmp++; if (dram_if.dram_req !== 1'b0) begin n_err++; $display("FAIL misalign_req_%0d: got %b want 0", i, dram_if.dram_req); end
      n_cmp++; if (cpu_if.resp_valid !== 1'b1 || cpu_if.resp_excp !== t_exc[i] || cpu_if.resp_sc_ok !== 1'b0) begin n_err++; $display("FAIL misalign_resp_%0d: got valid=%b excp=%b sc=%b want 1 %b 0", i, cpu_if.resp_valid, cpu_if.resp_excp, cpu_if.resp_sc_ok, t_exc[i]); end
      step();
    end
  endtask

  task automatic test_unknown_op();
    logic [3:0] t_op [3];
    t_op = '{4'd7, 4'd15, 4'd0};
    for (int i = 0; i < 3; i++) begin
      cpu_if.req_valid = 1'b1;
      cpu_if.req_op    = t_op[i];
      cpu_if.req_addr  = 32'h100;
      step();
      n_cmp++; if (cpu_if.req_ready !== 1'b1 || dram_if.dram_req !== 1'b0 || cpu_if.resp_valid !== 1'b0) begin n_err++; $display("FAIL unknown_op_%0d: got ready=%b req=%b valid=%b want 1 0 0", i, cpu_if.req_ready, dram_if.dram_req, cpu_if.resp_valid); end
    end
    cpu_if.req_valid = 1'b0;
    cpu_if.req_op    = 4'd0;
  endtask

  task automatic test_flush();
    cpu_if.flush = 1'b1;
    issue(MEM_OP_LW, 32'h100, 32'h0);
    cpu_if.flush = 1'b0;
    n_cmp++; if (dram_if.dram_req !== 1'b0 || cpu_if.req_ready !== 1'b1) begin n_err++; $display("FAIL flush_idle: got req=%b ready=%b want 0 1", dram_if.dram_req, cpu_if.req_ready); end
    issue(MEM_OP_LW, 32'h101, 32'h0);
    cpu_if.flush = 1'b1;
    #1;
    n_cmp++; if (cpu_if.resp_valid !== 1'b0) begin n_err++; $display("FAIL flush_resp: got %b want 0", cpu_if.resp_valid); end
    cpu_if.flush = 1'b0;
    step();
    issue(MEM_OP_LL, 32'h400, 32'h0);
    ack_cycle(32'h1122_3344);
    n_cmp++; if (cpu_if.resp_rdata !== 32'h1122_3344) begin n_err++; $display("FAIL ll_rdata: got %h want 11223344", cpu_if.resp_rdata); end
    step();
    issue(MEM_OP_LW, 32'h500, 32'h0);
    cpu_if.flush = 1'b1;
    step();
    cpu_if.flush = 1'b0;
    n_cmp++; if (dram_if.dram_req !== 1'b1 || cpu_if.resp_valid !== 1'b0) begin n_err++; $display("FAIL flush_bus_hold: got req=%b valid=%b want 1 0", dram_if.dram_req, cpu_if.resp_valid); end
    step();
    n_cmp++; if (dram_if.dram_req !== 1'b1) begin n_err++; $display("FAIL flush_bus_req: got %b want 1", dram_if.dram_req); end
    ack_cycle(32'h5555_5555);
    n_cmp++; if (cpu_if.resp_valid !== 1'b0 || dram_if.dram_req !== 1'b0) begin n_err++; $display("FAIL flush_bus_done: got valid=%b req=%b want 0 0", cpu_if.resp_valid, dram_if.dram_req); end
    step();
    n_cmp++; if (cpu_if.resp_valid !== 1'b0 || cpu_if.req_ready !== 1'b1) begin n_err++; $display("FAIL flush_bus_idle: got valid=%b ready=%b want 0 1", cpu_if.resp_valid, cpu_if.req_ready); end
    issue(MEM_OP_SC, 32'h400, 32'h5A);
`ifdef MEM_LLSC_EN
    n_cmp++; if (dram_if.dram_req !== 1'b0 || cpu_if.resp_valid !== 1'b1 || cpu_if.resp_sc_ok !== 1'b0) begin n_err++; $display("FAIL flush_link_sc: got req=%b valid=%b sc=%b want 0 1 0", dram_if.dram_req, cpu_if.resp_valid, cpu_if.resp_sc_ok); end
`else
    n_cmp++; if (dram_if.dram_req !== 1'b1 || dram_if.dram_we !== 4'b1111) begin n_err++; $display("FAIL flush_sc_write: got req=%b we=%b want 1 1111", dram_if.dram_req, dram_if.dram_we); end
    ack_cycle(32'h0);
    n_cmp++; if (cpu_if.resp_sc_ok !== 1'b1) begin n_err++; $display("FAIL flush_sc_ok: got %b want 1", cpu_if.resp_sc_ok); end
`endif
    step();
  endtask

  task automatic test_llsc();
`ifdef MEM_LLSC_EN
    issue(MEM_OP_LL, 32'h400, 32'h0);
    ack_cycle(32'h0);
    step();
    issue(MEM_OP_SW, 32'h400, 32'h77);
    ack_cycle(32'h0);
    step();
    issue(MEM_OP_SC, 32'h400, 32'h88);
    n_cmp++; if (dram_if.dram_req !== 1'b0 || cpu_if.resp_valid !== 1'b1 || cpu_if.resp_sc_ok !== 1'b0 || cpu_if.resp_excp !== 2'b00) begin n_err++; $display("FAIL sc_after_sw: got req=%b valid=%b sc=%b excp=%b want 0 1 0 00", dram_if.dram_req, cpu_if.resp_valid, cpu_if.resp_sc_ok, cpu_if.resp_excp); end
    step();
    issue(MEM_OP_LL, 32'h400, 32'h0);
    ack_cycle(32'h0);
    step();
    issue(MEM_OP_SC, 32'h400, 32'h99);
    n_cmp++; if (dram_if.dram_req !== 1'b1 || dram_if.dram_we !== 4'b1111) begin n_err++; $display("FAIL sc_linked_write: got req=%b we=%b want 1 1111", dram_if.dram_req, dram_if.dram_we); end
    ack_cycle(32'h0);
    n_cmp++; if (cpu_if.resp_valid !== 1'b1 || cpu_if.resp_sc_ok !== 1'b1) begin n_err++; $display("FAIL sc_linked_ok: got valid=%b sc=%b want 1 1", cpu_if.resp_valid, cpu_if.resp_sc_ok); end
    step();
    issue(MEM_OP_SC, 32'h400, 32'h99);
    n_cmp++; if (dram_if.dram_req !== 1'b0 || cpu_if.resp_sc_ok !== 1'b0) begin n_err++; $display("FAIL sc_consumed: got req=%b sc=%b want 0 0", dram_if.dram_req, cpu_if.resp_sc_ok); end
    step();
    issue(MEM_OP_LL, 32'h400, 32'h0);
    ack_cycle(32'h0);
    step();
    issue(MEM_OP_SC, 32'h404, 32'h99);
    n_cmp++; if (dram_if.dram_req !== 1'b0 || cpu_if.resp_sc_ok !== 1'b0) begin n_err++; $display("FAIL sc_other_addr: got req=%b sc=%b want 0 0", dram_if.dram_req, cpu_if.resp_sc_ok); end
    step();
`else
    issue(MEM_OP_LL, 32'h400, 32'h0);
    ack_cycle(32'h80FF_1234);
    n_cmp++; if (cpu_if.resp_rdata !== 32'h80FF_1234) begin n_err++; $display("FAIL ll_as_lw: got %h want 80ff1234", cpu_if.resp_rdata); end
    step();
    issue(MEM_OP_SC, 32'h404, 32'h99);
    n_cmp++; if (dram_if.dram_req !== 1'b1 || dram_if.dram_we !== 4'b1111) begin n_err++; $display("FAIL sc_as_sw: got req=%b we=%b want 1 1111", dram_if.dram_req, dram_if.dram_we); end
    ack_cycle(32'h0);
    n_cmp++; if (cpu_if.resp_sc_ok !== 1'b1) begin n_err++; $display("FAIL sc_ok_always: got %b want 1", cpu_if.resp_sc_ok); end
    step();
`endif
  endtask

  task automatic test_timeout();
    int cnt;
    issue(MEM_OP_LW, 32'h600, 32'h0);
    cnt = 0;
    while (dram_if.dram_req === 1'b1 && cnt < 20) begin
      cnt++;
      step();
    end
    n_cmp++; if (cnt !== 4) begin n_err++; $display("FAIL timeout_req_cycles: got %0d want 4", cnt); end
    n_cmp++; if (cpu_if.resp_valid !== 1'b1 || cpu_if.resp_excp !== 2'b11) begin n_err++; $display("FAIL timeout_resp: got valid=%b excp=%b want 1 11", cpu_if.resp_valid, cpu_if.resp_excp); end
    step();
  endtask

  task automatic test_back_to_back();
    issue(MEM_OP_SW, 32'h800, 32'h0BAD_F00D);
    ack_cycle(32'h0);
    cpu_if.req_valid = 1'b1;
    cpu_if.req_op    = MEM_OP_LW;
    cpu_if.req_addr  = 32'h800;
    n_cmp++; if (cpu_if.req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_in_resp: got %b want 0", cpu_if.req_ready); end
    step();
    step();
    cpu_if.req_valid = 1'b0;
    n_cmp++; if (dram_if.dram_req !== 1'b1 || dram_if.dram_we !== 4'b0000 || dram_if.dram_addr !== 32'h800) begin n_err++; $display("FAIL b2b_second: got req=%b we=%b addr=%h want 1 0000 00000800", dram_if.dram_req, dram_if.dram_we, dram_if.dram_addr); end
    ack_cycle(32'h0BAD_F00D);
    n_cmp++; if (cpu_if.resp_rdata !== 32'h0BAD_F00D) begin n_err++; $display("FAIL b2b_rdata: got %h want 0badf00d", cpu_if.resp_rdata); end
    step();
  endtask

  task automatic test_reset_mid();
    issue(MEM_OP_LW, 32'h700, 32'h0);
    n_cmp++; if (dram_if.dram_req !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got %b want 1", dram_if.dram_req); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dram_if.dram_req !== 1'b0 || cpu_if.req_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_async: got req=%b ready=%b want 0 1", dram_if.dram_req, cpu_if.req_ready); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    cpu_if.req_valid   = 1'b0;
    cpu_if.req_op      = 4'd0;
    cpu_if.req_addr    = 32'h0;
    cpu_if.req_wdata   = 32'h0;
    cpu_if.flush       = 1'b0;
    dram_if.dram_ack   = 1'b0;
    dram_if.dram_rdata = 32'h0;
    test_reset();
    test_lb_latency();
    test_store_lanes();
    test_load_ext();
    test_misaligned();
    test_unknown_op();
    test_flush();
    test_llsc();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
